// File: rtl/axis_frame_len_prefix_pkg.sv
// rtl/axis_frame_len_prefix_pkg.sv - shared types and constants for the length-prefix stage
//
// Purpose: frame FSM state encoding, prefix lengths and flag-byte bit positions
//          used by axis_frame_len_prefix.
// Ports:   none (package).

package axis_frame_len_prefix_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PREFIX  = 2'd1,
      PAYLOAD = 2'd2,
      DROP    = 2'd3
   } state_t;

   // Prefix = flag byte + 2 length bytes (+ 2 original-length bytes).
   localparam int PREFIX_LEN_SHORT = 3;
   localparam int PREFIX_LEN_LONG  = 5;

   localparam int FLAG_PAD_BIT   = 1;
   localparam int FLAG_TRUNC_BIT = 0;

   function automatic logic [7:0] make_flags(input logic pad, input logic trunc);
      logic [7:0] f;
      f                 = 8'h00;
      f[FLAG_PAD_BIT]   = pad;
      f[FLAG_TRUNC_BIT] = trunc;
      return f;
   endfunction

endpackage

// File: rtl/axis_frame_len_prefix.sv
// rtl/axis_frame_len_prefix.sv - prepends a length/flag prefix to each frame and checks payload length
//
// Purpose: for every header taken from the length-adjust FIFO, emit a prefix
//          ({flags}, length, optional original length) followed by the payload,
//          cutting or flagging payloads whose beat count disagrees with the header.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   s_axis_hdr_*                header stream (valid/ready, pad, truncate, length, original_length)
//   s_axis_t*                   byte payload stream in (tdata/tvalid/tready/tlast/tuser)
//   m_axis_t*                   registered byte stream out (tdata/tvalid/tready/tlast/tuser)
//   status_len_mismatch         one-cycle pulse per frame whose payload length disagreed

module axis_frame_len_prefix
   import axis_frame_len_prefix_pkg::*;
#(
   parameter int ORIG_LEN_ENABLE = 1,
   parameter int USER_ENABLE     = 1,
   parameter int USER_WIDTH      = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_axis_hdr_valid,
   output logic                  s_axis_hdr_ready,
   input  logic                  s_axis_hdr_pad,
   input  logic                  s_axis_hdr_truncate,
   input  logic [15:0]           s_axis_hdr_length,
   input  logic [15:0]           s_axis_hdr_original_length,
   input  logic [7:0]            s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic [USER_WIDTH-1:0] s_axis_tuser,
   output logic [7:0]            m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [USER_WIDTH-1:0] m_axis_tuser,
   output logic                  status_len_mismatch
);

   localparam int         PREFIX_LEN  = (ORIG_LEN_ENABLE != 0) ? PREFIX_LEN_LONG : PREFIX_LEN_SHORT;
   localparam logic [2:0] PREFIX_LAST = 3'(PREFIX_LEN - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_pad;
   logic                  r_trunc;
   logic [15:0]           r_len;
   logic [15:0]           r_orig;
   logic [15:0]           r_cnt;
   logic [2:0]            r_pfx_idx;

   logic [7:0]            r_m_tdata;
   logic                  r_m_tvalid;
   logic                  r_m_tlast;
   logic [USER_WIDTH-1:0] r_m_tuser;
   logic                  r_mismatch;

   logic                  w_load;
   logic                  w_hdr_fire;
   logic                  w_dat_fire;
   logic                  w_pfx_adv;
   logic                  w_emit;
   logic [7:0]            w_emit_data;
   logic                  w_emit_last;
   logic [USER_WIDTH-1:0] w_emit_user;
   logic                  w_mismatch;
   logic [7:0]            w_pfx_byte;
   logic [15:0]           w_cnt_inc;
   logic                  w_cnt_hit;
   logic [USER_WIDTH-1:0] w_user_in;

   // Output register may take a new beat when empty or being drained.
   assign w_load = !r_m_tvalid || m_axis_tready;

   // In PAYLOAD the counter is always below r_len, so +1 never wraps even at 65535.
   assign w_cnt_inc = r_cnt + 16'd1;
   assign w_cnt_hit = (w_cnt_inc == r_len);

   assign w_user_in = (USER_ENABLE != 0) ? s_axis_tuser : '0;

   always_comb begin
      w_pfx_byte = 8'h00;
      case (r_pfx_idx)
         3'd0:    w_pfx_byte = make_flags(r_pad, r_trunc);
         3'd1:    w_pfx_byte = r_len[15:8];
         3'd2:    w_pfx_byte = r_len[7:0];
         3'd3:    w_pfx_byte = r_orig[15:8];
         default: w_pfx_byte = r_orig[7:0];
      endcase
   end

   always_comb begin
      w_state_nxt      = r_state;
      s_axis_hdr_ready = 1'b0;
      s_axis_tready    = 1'b0;
      w_hdr_fire       = 1'b0;
      w_dat_fire       = 1'b0;
      w_pfx_adv        = 1'b0;
      w_emit           = 1'b0;
      w_emit_data      = 8'h00;
      w_emit_last      = 1'b0;
      w_emit_user      = '0;
      w_mismatch       = 1'b0;

      case (r_state)
         IDLE: begin
            s_axis_hdr_ready = 1'b1;
            if (s_axis_hdr_valid) begin
               w_hdr_fire  = 1'b1;
               w_state_nxt = PREFIX;
            end
         end

         PREFIX: begin
            if (w_load) begin
               w_emit      = 1'b1;
               w_emit_data = w_pfx_byte;
               w_pfx_adv   = 1'b1;
               if (r_pfx_idx == PREFIX_LAST) begin
                  // A zero-length frame ends on its prefix; its input is discarded.
                  w_emit_last = (r_len == 16'd0);
                  w_state_nxt = (r_len == 16'd0) ? DROP : PAYLOAD;
               end
            end
         end

         PAYLOAD: begin
            s_axis_tready = w_load;
            if (s_axis_tvalid && w_load) begin
               w_dat_fire  = 1'b1;
               w_emit      = 1'b1;
               w_emit_data = s_axis_tdata;
               w_emit_user = w_user_in;
               if (s_axis_tlast) begin
                  w_emit_last = 1'b1;
                  w_state_nxt = IDLE;
                  if (!w_cnt_hit) begin
                     // Short frame: mark the truncated tail in tuser[0].
                     w_emit_user = w_user_in | USER_WIDTH'(1);
                     w_mismatch  = 1'b1;
                  end
               end else if (w_cnt_hit) begin
                  // Long frame: close the output here, swallow the rest.
                  w_emit_last = 1'b1;
                  w_mismatch  = 1'b1;
                  w_state_nxt = DROP;
               end
            end
         end

         DROP: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) begin
               w_state_nxt = IDLE;
            end
         end

         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_pad      <= 1'b0;
         r_trunc    <= 1'b0;
         r_len      <= 16'd0;
         r_orig     <= 16'd0;
         r_cnt      <= 16'd0;
         r_pfx_idx  <= 3'd0;
         r_m_tdata  <= 8'h00;
         r_m_tvalid <= 1'b0;
         r_m_tlast  <= 1'b0;
         r_m_tuser  <= '0;
         r_mismatch <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_mismatch <= w_mismatch;

         if (w_hdr_fire) begin
            r_pad     <= s_axis_hdr_pad;
            r_trunc   <= s_axis_hdr_truncate;
            r_len     <= s_axis_hdr_length;
            r_orig    <= s_axis_hdr_original_length;
            r_cnt     <= 16'd0;
            r_pfx_idx <= 3'd0;
         end

         if (w_pfx_adv) begin
            r_pfx_idx <= r_pfx_idx + 3'd1;
         end

         if (w_dat_fire) begin
            r_cnt <= w_cnt_inc;
         end

         if (w_load) begin
            r_m_tvalid <= w_emit;
            r_m_tdata  <= w_emit_data;
            r_m_tlast  <= w_emit_last;
            r_m_tuser  <= w_emit_user;
         end
      end
   end

   assign m_axis_tdata        = r_m_tdata;
   assign m_axis_tvalid       = r_m_tvalid;
   assign m_axis_tlast        = r_m_tlast;
   assign m_axis_tuser        = r_m_tuser;
   assign status_len_mismatch = r_mismatch;

endmodule

// File: tb/tb_axis_frame_len_prefix.sv
// tb/tb_axis_frame_len_prefix.sv - self-checking bench for axis_frame_len_prefix

module tb_axis_frame_len_prefix;

   localparam int NF     = 32;
   localparam int BUDGET = 500;

   logic        clk;
   logic        rst_n;

   logic        hdr_valid, hdr_ready, hdr_pad, hdr_trunc;
   logic [15:0] hdr_len, hdr_orig;
   logic [7:0]  s_tdata;
   logic        s_tvalid, s_tready, s_tlast;
   logic [0:0]  s_tuser;
   logic [7:0]  m_tdata;
   logic        m_tvalid, m_tready, m_tlast;
   logic [0:0]  m_tuser;
   logic        mm;

   logic        b_hdr_valid, b_hdr_ready, b_hdr_pad, b_hdr_trunc;
   logic [15:0] b_hdr_len, b_hdr_orig;
   logic [7:0]  b_s_tdata;
   logic        b_s_tvalid, b_s_tready, b_s_tlast;
   logic [0:0]  b_s_tuser;
   logic [7:0]  b_m_tdata;
   logic        b_m_tvalid, b_m_tready, b_m_tlast;
   logic [0:0]  b_m_tuser;
   logic        b_mm;

   axis_frame_len_prefix #(.ORIG_LEN_ENABLE(1), .USER_ENABLE(1), .USER_WIDTH(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_hdr_valid(hdr_valid), .s_axis_hdr_ready(hdr_ready),
      .s_axis_hdr_pad(hdr_pad), .s_axis_hdr_truncate(hdr_trunc),
      .s_axis_hdr_length(hdr_len), .s_axis_hdr_original_length(hdr_orig),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
      .status_len_mismatch(mm)
   );

   axis_frame_len_prefix #(.ORIG_LEN_ENABLE(0), .USER_ENABLE(1), .USER_WIDTH(1)) dut_short (
      .clk(clk), .rst_n(rst_n),
      .s_axis_hdr_valid(b_hdr_valid), .s_axis_hdr_ready(b_hdr_ready),
      .s_axis_hdr_pad(b_hdr_pad), .s_axis_hdr_truncate(b_hdr_trunc),
      .s_axis_hdr_length(b_hdr_len), .s_axis_hdr_original_length(b_hdr_orig),
      .s_axis_tdata(b_s_tdata), .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready),
      .s_axis_tlast(b_s_tlast), .s_axis_tuser(b_s_tuser),
      .m_axis_tdata(b_m_tdata), .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready),
      .m_axis_tlast(b_m_tlast), .m_axis_tuser(b_m_tuser),
      .status_len_mismatch(b_mm)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Frame table
   int          f_len  [NF];
   int          f_n    [NF];
   logic [15:0] f_orig [NF];
   logic        f_pad  [NF];
   logic        f_trunc[NF];
   logic [7:0]  f_data [NF][16];
   logic        f_user [NF][16];

   // Expected output beats
   logic [7:0]  q_data[$];
   logic        q_last[$];
   logic        q_user[$];
   int          exp_mm  = 0;
   int          mm_seen = 0;

   logic        rand_mode = 1'b0;
   logic        ignore    = 1'b0;

   task automatic set_frame(input int k, input logic pad, input logic trunc, input int len,
                            input logic [15:0] orig, input int n, input logic [7:0] base);
      f_pad[k] = pad; f_trunc[k] = trunc; f_len[k] = len; f_orig[k] = orig; f_n[k] = n;
      for (int i = 0; i < 16; i++) begin
         f_data[k][i] = base + 8'(i);
         f_user[k][i] = 1'b0;
      end
   endtask

   task automatic push_beat(input logic [7:0] d, input logic l, input logic u);
      q_data.push_back(d); q_last.push_back(l); q_user.push_back(u);
   endtask

   // Output = flag byte, length, original length, then min(n, len) payload bytes.
   task automatic build_expected(input int k);
      int          m;
      logic        u;
      logic [15:0] len16;
      len16 = f_len[k][15:0];
      push_beat({6'b0, f_pad[k], f_trunc[k]}, 1'b0, 1'b0);
      push_beat(len16[15:8], 1'b0, 1'b0);
      push_beat(len16[7:0], 1'b0, 1'b0);
      push_beat(f_orig[k][15:8], 1'b0, 1'b0);
      push_beat(f_orig[k][7:0], f_len[k] == 0, 1'b0);
      if (f_len[k] != 0) begin
         m = (f_n[k] < f_len[k]) ? f_n[k] : f_len[k];
         for (int i = 0; i < m; i++) begin
            u = f_user[k][i];
            if (i == m - 1 && f_n[k] < f_len[k]) u = 1'b1;
            push_beat(f_data[k][i], i == m - 1, u);
         end
         if (f_n[k] != f_len[k]) exp_mm++;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         m_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Compare process
   logic       frame_open = 1'b0;
   logic       prev_stall = 1'b0;
   logic [7:0] pd;
   logic       pl, pu;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            frame_open = 1'b0;
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("hold_valid", m_tvalid, 1'b1);
               check("hold_data", m_tdata, pd);
               check("hold_last", m_tlast, pl);
               check("hold_user", m_tuser, pu);
            end
            if (m_tvalid && m_tready && !ignore) begin
               if (q_data.size() == 0) begin
                  check("unexpected_beat", m_tdata, 32'hFFFF_FFFF);
               end else begin
                  check("beat_data", m_tdata, q_data.pop_front());
                  check("beat_last", m_tlast, q_last.pop_front());
                  check("beat_user", m_tuser, q_user.pop_front());
               end
            end
            if (mm) mm_seen++;
            if (frame_open) check("hdr_ready_while_frame_open", hdr_ready, 1'b0);
            if (hdr_valid && hdr_ready) frame_open = 1'b1;
            if (s_tvalid && s_tready && s_tlast) frame_open = 1'b0;
            prev_stall = m_tvalid && !m_tready;
            pd = m_tdata; pl = m_tlast; pu = m_tuser[0];
         end
      end
   end

   task automatic drive_hdrs(input int first, input int cnt);
      int t;
      for (int k = first; k < first + cnt; k++) begin
         hdr_pad = f_pad[k]; hdr_trunc = f_trunc[k];
         hdr_len = f_len[k][15:0]; hdr_orig = f_orig[k];
         hdr_valid = 1'b1;
         t = 0;
         forever begin
            @(negedge clk);
            if (hdr_ready) break;
            t++;
            if (t > BUDGET) break;
         end
         if (t > BUDGET) check("hdr_timeout", t, 0);
         @(posedge clk);
         #1;
         hdr_valid = 1'b0;
      end
   endtask

   task automatic drive_data(input int first, input int cnt);
      int t;
      for (int k = first; k < first + cnt; k++) begin
         for (int i = 0; i < f_n[k]; i++) begin
            s_tdata = f_data[k][i]; s_tuser = f_user[k][i];
            s_tlast = (i == f_n[k] - 1); s_tvalid = 1'b1;
            t = 0;
            forever begin
               @(negedge clk);
               if (s_tready) break;
               t++;
               if (t > BUDGET) break;
            end
            if (t > BUDGET) check("data_timeout", t, 0);
            @(posedge clk);
            #1;
         end
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
   endtask

   task automatic run_frames(input int first, input int cnt);
      int t;
      @(posedge clk);
      #1;
      fork
         drive_hdrs(first, cnt);
         drive_data(first, cnt);
      join
      t = 0;
      while (q_data.size() != 0 && t < BUDGET) begin
         @(negedge clk);
         t++;
      end
      check("drain_left", q_data.size(), 0);
      q_data.delete(); q_last.delete(); q_user.delete();
      repeat (3) @(posedge clk);
      #1;
      check("mismatch_count", mm_seen, exp_mm);
   endtask

   logic [7:0] lit0[9];
   logic [7:0] lit_b[6];
   logic [7:0] got_b[6];
   logic       got_bl[6];

   initial begin
      int t, nb, bmm;
      rst_n = 1'b0;
      hdr_valid = 0; hdr_pad = 0; hdr_trunc = 0; hdr_len = 0; hdr_orig = 0;
      s_tdata = 0; s_tvalid = 0; s_tlast = 0; s_tuser = 0; m_tready = 1;
      b_hdr_valid = 0; b_hdr_pad = 0; b_hdr_trunc = 0; b_hdr_len = 0; b_hdr_orig = 0;
      b_s_tdata = 0; b_s_tvalid = 0; b_s_tlast = 0; b_s_tuser = 0; b_m_tready = 1;

      repeat (3) @(posedge clk);
      #1;
      check("rst_m_tvalid", m_tvalid, 0);
      check("rst_m_tdata", m_tdata, 0);
      check("rst_m_tlast", m_tlast, 0);
      check("rst_m_tuser", m_tuser, 0);
      check("rst_mismatch", mm, 0);
      check("rst_s_tready", s_tready, 0);
      rst_n = 1'b1;

      // Basic frame
      set_frame(0, 0, 0, 4, 16'd4, 4, 8'h00);
      f_data[0][0] = 8'hAA; f_data[0][1] = 8'hBB; f_data[0][2] = 8'hCC; f_data[0][3] = 8'hDD;
      build_expected(0);
      lit0 = '{8'h00, 8'h00, 8'h04, 8'h00, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      check("pin0_size", q_data.size(), 9);
      for (int i = 0; i < 9; i++) check("pin0_byte", q_data[i], lit0[i]);
      check("pin0_last", {q_last[7], q_last[8]}, 2'b01);
      run_frames(0, 1);

      // Long payload: len=2, 5 bytes
      set_frame(1, 0, 1, 2, 16'd5, 5, 8'h10);
      build_expected(1);
      check("pin1_size", q_data.size(), 7);
      check("pin1_lastbyte", {q_data[6], 7'b0, q_last[6]}, {8'h11, 8'h01});
      run_frames(1, 1);

      // Short payload: len=6, 3 bytes
      set_frame(2, 1, 0, 6, 16'd3, 3, 8'h20);
      build_expected(2);
      check("pin2_size", q_data.size(), 8);
      check("pin2_tail", {q_data[7], 6'b0, q_last[7], q_user[7]}, {8'h22, 8'h03});
      check("pin2_flags", q_data[0], 8'h02);
      run_frames(2, 1);

      // Zero length with a 1-byte input frame
      set_frame(3, 0, 0, 0, 16'd1, 1, 8'h30);
      build_expected(3);
      check("pin3_size", q_data.size(), 5);
      check("pin3_last", {q_last[3], q_last[4]}, 2'b01);
      run_frames(3, 1);

      // tuser propagation, both flags
      set_frame(4, 1, 1, 3, 16'd3, 3, 8'h40);
      f_user[4][0] = 1'b1; f_user[4][2] = 1'b1;
      build_expected(4);
      run_frames(4, 1);

      // Max length, short payload
      set_frame(5, 0, 0, 65535, 16'hFFFF, 3, 8'h50);
      build_expected(5);
      check("pin5_len", {q_data[1], q_data[2]}, 16'hFFFF);
      run_frames(5, 1);

      // Back-pressure run over 20 frames
      for (int k = 10; k < 30; k++) begin
         set_frame(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 6)), 16'($urandom), int'($urandom_range(1, 8)),
                   8'($urandom));
         for (int i = 0; i < 16; i++) f_user[k][i] = 1'($urandom_range(0, 1));
         build_expected(k);
      end
      rand_mode = 1'b1;
      run_frames(10, 20);
      rand_mode = 1'b0;

      // Reset mid-payload
      ignore = 1'b1;
      @(posedge clk);
      #1;
      hdr_pad = 0; hdr_trunc = 0; hdr_len = 16'd8; hdr_orig = 16'd8; hdr_valid = 1'b1;
      t = 0;
      while (!hdr_ready && t < BUDGET) begin @(negedge clk); t++; end
      check("rst_test_hdr", hdr_ready, 1);
      @(posedge clk);
      #1;
      hdr_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s_tdata = 8'h70 + 8'(i); s_tlast = 1'b0; s_tuser = 0; s_tvalid = 1'b1;
         t = 0;
         forever begin
            @(negedge clk);
            if (s_tready || t > BUDGET) break;
            t++;
         end
         @(posedge clk);
         #1;
      end
      #2;
      rst_n = 1'b0;
      #1;
      s_tvalid = 1'b0;
      check("midrst_m_tvalid", m_tvalid, 0);
      check("midrst_m_tlast", m_tlast, 0);
      check("midrst_m_tdata", m_tdata, 0);
      check("midrst_mismatch", mm, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      ignore = 1'b0;
      set_frame(6, 0, 1, 2, 16'd2, 2, 8'h60);
      build_expected(6);
      run_frames(6, 1);

      // Three-byte prefix variant
      lit_b = '{8'h02, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03};
      nb = 0; bmm = 0;
      @(posedge clk);
      #1;
      fork
         begin
            b_hdr_pad = 1; b_hdr_trunc = 0; b_hdr_len = 16'd3; b_hdr_orig = 16'd3; b_hdr_valid = 1;
            t = 0;
            forever begin
               @(negedge clk);
               if (b_hdr_ready || t > BUDGET) break;
               t++;
            end
            @(posedge clk);
            #1;
            b_hdr_valid = 0;
            for (int i = 0; i < 3; i++) begin
               b_s_tdata = 8'(i + 1); b_s_tlast = (i == 2); b_s_tvalid = 1;
               for (int w = 0; w < BUDGET; w++) begin
                  @(negedge clk);
                  if (b_s_tready) break;
               end
               @(posedge clk);
               #1;
            end
            b_s_tvalid = 0; b_s_tlast = 0;
         end
         begin
            for (int c = 0; c < BUDGET && nb < 6; c++) begin
               @(negedge clk);
               if (b_mm) bmm++;
               if (b_m_tvalid && b_m_tready) begin
                  got_b[nb] = b_m_tdata; got_bl[nb] = b_m_tlast; nb++;
               end
            end
         end
      join
      repeat (3) begin @(negedge clk); if (b_mm) bmm++; end
      check("short_prefix_count", nb, 6);
      for (int i = 0; i < 6; i++) begin
         if (i < nb) begin
            check("short_prefix_byte", got_b[i], lit_b[i]);
            check("short_prefix_last", got_bl[i], i == 5);
         end
      end
      check("short_prefix_mismatch", bmm, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
